// File: rtl/fpd32_div_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fpd32_div_scheduler: round-robin sharing of one multi-cycle FP32 divider  |
// | with divide-by-zero bypass and a WAIT-state watchdog.   Rev 1.0           |
// +--------------------------------------------------------------------------+
module fpd32_div_scheduler #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [32*NUM_REQ-1:0]  req_dividend,
   input  logic [32*NUM_REQ-1:0]  req_divisor,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [31:0]            rsp_quotient,
   output logic                   rsp_err,
   output logic                   div_start,
   output logic [31:0]            div_dividend,
   output logic [31:0]            div_divisor,
   input  logic                   div_done,
   input  logic [31:0]            div_quotient
);

   localparam int              CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [ID_W-1:0] GRANT_RST = ID_W'(NUM_REQ - 1);
   localparam logic [31:0]     QNAN      = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   last_grant_q, last_grant_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       quot_q, quot_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              grant_found;
   logic [ID_W-1:0]   grant;
   logic [31:0]       sel_a;
   logic [31:0]       sel_b;

   // Scan starts one past the last winner so every requester gets a turn.
   always_comb begin : arbiter
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant       = '0;
      sel_a       = '0;
      sel_b       = '0;
      for (int off = 1; off <= NUM_REQ; off++) begin
         idx = (int'(last_grant_q) + off) % NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant       = ID_W'(idx);
            sel_a       = req_dividend[32*idx +: 32];
            sel_b       = req_divisor[32*idx +: 32];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == S_IDLE && grant_found && rst_n) begin
         req_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      quot_d       = quot_q;
      err_d        = err_q;
      cnt_d        = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               id_d = grant;
               a_d  = sel_a;
               b_d  = sel_b;
               if (sel_b[30:0] == 31'd0) begin
                  quot_d  = {sel_a[31] ^ sel_b[31], 8'hFF, 23'd0};
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  state_d = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            // A completion arriving on the watchdog's last cycle still counts.
            if (div_done) begin
               quot_d  = div_quotient;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               quot_d  = QNAN;
               err_d   = 1'b1;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               last_grant_d = id_q;
               state_d      = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         last_grant_q <= GRANT_RST;
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         quot_q       <= '0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         quot_q       <= quot_d;
         err_q        <= err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign rsp_valid    = (state_q == S_RESP);
   assign rsp_id       = id_q;
   assign rsp_quotient = quot_q;
   assign rsp_err      = err_q;
   assign div_start    = (state_q == S_ISSUE);
   assign div_dividend = a_q;
   assign div_divisor  = b_q;

endmodule
`default_nettype wire

// File: tb/tb_fpd32_div_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fpd32_div_scheduler: randomized bench with a transaction-level model.  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fpd32_div_scheduler;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TIMEOUT = 64;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [32*NUM_REQ-1:0] req_dividend;
   logic [32*NUM_REQ-1:0] req_divisor;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [ID_W-1:0]       rsp_id;
   logic [31:0]           rsp_quotient;
   logic                  rsp_err;
   logic                  div_start;
   logic [31:0]           div_dividend;
   logic [31:0]           div_divisor;
   logic                  div_done;
   logic [31:0]           div_quotient;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] opa [NUM_REQ];
   logic [31:0] opb [NUM_REQ];
   int          model_last;
   int          dv_k;
   bit          dv_en;
   logic [31:0] dv_ans;
   logic        done_r;
   logic        extra_done;
   logic [31:0] div_q_r;

   assign div_done     = done_r | extra_done;
   assign div_quotient = div_q_r;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         req_dividend[32*i +: 32] = opa[i];
         req_divisor[32*i +: 32]  = opb[i];
      end
   end

   fpd32_div_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_quotient(rsp_quotient), .rsp_err(rsp_err),
      .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
      .div_done(div_done), .div_quotient(div_quotient)
   );

   always #5 clk = ~clk;

   // Behavioural divider: answers dv_k cycles after the start pulse when enabled.
   initial begin : divider_model
      int          k;
      logic [31:0] ans;
      done_r  = 1'b0;
      div_q_r = '0;
      forever begin
         @(negedge clk);
         if (div_start === 1'b1 && dv_en) begin
            k   = dv_k;
            ans = dv_ans;
            repeat (k) @(posedge clk);
            #1;
            done_r  = 1'b1;
            div_q_r = ans;
            @(posedge clk);
            #1;
            done_r  = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL global_timeout: simulation did not finish, got running expected finished");
      $fatal(1);
   end

   function automatic int exp_grant(input logic [NUM_REQ-1:0] mask, input int last);
      for (int off = 1; off <= NUM_REQ; off++) begin
         if (mask[(last + off) % NUM_REQ]) return (last + off) % NUM_REQ;
      end
      return 0;
   endfunction

   // One operation end-to-end, predicted from the transaction rules alone.
   task automatic run_txn(input string tag, input logic [NUM_REQ-1:0] mask, input int k,
                          input bit en, input logic [31:0] ans, input int stall, input bit extra);
      int          g, lat, exp_lat;
      bit          dz, done_ok;
      logic [31:0] ea, eb, eq;
      logic        eerr;
      g       = exp_grant(mask, model_last);
      ea      = opa[g];
      eb      = opb[g];
      dz      = (eb[30:0] == 31'd0);
      done_ok = en && (k <= TIMEOUT);
      if (dz) begin
         eq = {ea[31] ^ eb[31], 8'hFF, 23'd0}; eerr = 1'b1; exp_lat = 1;
      end else if (done_ok) begin
         eq = ans; eerr = 1'b0; exp_lat = k + 2;
      end else begin
         eq = 32'h7FC00000; eerr = 1'b1; exp_lat = TIMEOUT + 2;
      end
      dv_k = k; dv_en = en; dv_ans = ans;
      req_valid = mask;
      #1;
      checks++;
      if (req_ready !== NUM_REQ'(1 << g)) begin
         errors++;
         $display("FAIL %s grant: req_ready got %b expected %b", tag, req_ready, NUM_REQ'(1 << g));
      end
      @(posedge clk); #1;
      checks++;
      if (div_start !== !dz || div_dividend !== ea || div_divisor !== eb || req_ready !== '0) begin
         errors++;
         $display("FAIL %s issue: start=%b a=%h b=%h rdy=%b expected start=%b a=%h b=%h rdy=0",
                  tag, div_start, div_dividend, div_divisor, req_ready, !dz, ea, eb);
      end
      opa[g] = $urandom;
      opb[g] = $urandom;
      lat = 1;
      while (rsp_valid !== 1'b1 && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d expected %0d", tag, lat, exp_lat);
      end
      checks++;
      if (rsp_id !== ID_W'(g) || rsp_quotient !== eq || rsp_err !== eerr) begin
         errors++;
         $display("FAIL %s response: id=%0d q=%h err=%b expected id=%0d q=%h err=%b",
                  tag, rsp_id, rsp_quotient, rsp_err, g, eq, eerr);
      end
      for (int s = 0; s < stall; s++) begin
         if (s == 0 && extra) extra_done = 1'b1;
         @(posedge clk); #1;
         extra_done = 1'b0;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== ID_W'(g) || rsp_quotient !== eq ||
             rsp_err !== eerr || req_ready !== '0 || div_dividend !== ea || div_divisor !== eb) begin
            errors++;
            $display("FAIL %s stall%0d: v=%b id=%0d q=%h err=%b rdy=%b a=%h expected v=1 id=%0d q=%h err=%b rdy=0 a=%h",
                     tag, s, rsp_valid, rsp_id, rsp_quotient, rsp_err, req_ready, div_dividend,
                     g, eq, eerr, ea);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready  = 1'b0;
      req_valid  = '0;
      model_last = g;
      checks++;
      if (rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL %s release: rsp_valid got %b expected 0", tag, rsp_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_quotient !== '0 ||
          rsp_err !== 1'b0 || div_start !== 1'b0 || div_dividend !== '0 || div_divisor !== '0) begin
         errors++;
         $display("FAIL reset_outputs: rdy=%b v=%b id=%0d q=%h err=%b st=%b a=%h b=%h expected all zero",
                  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_err, div_start, div_dividend, div_divisor);
      end
      rst_n = 1'b1;
      model_last = NUM_REQ - 1;
   endtask

   task automatic test_single_divide();
      opa[0] = 32'h40C00000;
      opb[0] = 32'h40000000;
      run_txn("single_div", 4'b0001, 24, 1'b1, 32'h40400000, 0, 1'b0);
   endtask

   task automatic test_round_robin();
      for (int n = 0; n < 5; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = $urandom; opb[i] = $urandom | 32'h1;
         end
         run_txn("round_robin", 4'b1111, $urandom_range(1, 5), 1'b1, $urandom, 0, 1'b0);
      end
   endtask

   task automatic test_div_zero();
      opa[1] = 32'h3F800000; opb[1] = 32'h80000000;
      run_txn("div_zero_neg", 4'b0010, 5, 1'b1, $urandom, 0, 1'b0);
      opa[3] = 32'hC1200000; opb[3] = 32'h00000000;
      run_txn("div_zero_pos", 4'b1000, 5, 1'b1, $urandom, 0, 1'b0);
      opa[2] = 32'h3F800000; opb[2] = 32'h00000001;
      run_txn("denormal_divisor", 4'b0100, 3, 1'b1, $urandom, 0, 1'b0);
   endtask

   task automatic test_timeout();
      opa[0] = 32'h3F800000; opb[0] = 32'h40400000;
      run_txn("timeout", 4'b0001, 1, 1'b0, $urandom, 0, 1'b0);
      opa[1] = 32'h3F800000; opb[1] = 32'h40400000;
      run_txn("done_at_timeout", 4'b0010, TIMEOUT, 1'b1, $urandom, 0, 1'b0);
      opa[2] = 32'h3F800000; opb[2] = 32'h40400000;
      run_txn("done_before_timeout", 4'b0100, TIMEOUT - 1, 1'b1, $urandom, 0, 1'b0);
   endtask

   task automatic test_backpressure();
      opa[3] = 32'h41000000; opb[3] = 32'h40800000;
      run_txn("backpressure", 4'b1111, 4, 1'b1, 32'h40000000, 10, 1'b1);
      opa[0] = 32'h41000000; opb[0] = 32'h00000000;
      run_txn("backpressure_dz", 4'b1111, 4, 1'b1, $urandom, 10, 1'b1);
   endtask

   task automatic test_reset_in_wait();
      opa[2] = 32'h12345678; opb[2] = 32'h40400000;
      dv_en = 1'b0;
      req_valid = 4'b0100;
      @(posedge clk); #1;
      req_valid = '0;
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_quotient !== '0 ||
          rsp_err !== 1'b0 || div_start !== 1'b0 || div_dividend !== '0 || div_divisor !== '0) begin
         errors++;
         $display("FAIL reset_in_wait: rdy=%b v=%b id=%0d q=%h err=%b st=%b a=%h b=%h expected all zero",
                  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_err, div_start, div_dividend, div_divisor);
      end
      rst_n = 1'b1;
      model_last = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) begin
         opa[i] = $urandom; opb[i] = $urandom | 32'h1;
      end
      run_txn("after_reset", 4'b1111, 2, 1'b1, $urandom, 0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < NUM_REQ; i++) begin
         opa[i] = $urandom; opb[i] = {1'($urandom_range(0, 1)), 31'd0};
      end
      for (int n = 0; n < 4; n++) begin
         opb[(model_last + 1) % NUM_REQ] = {1'($urandom_range(0, 1)), 31'd0};
         run_txn("back_to_back_dz", 4'b1111, 1, 1'b1, $urandom, 0, 1'b0);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = $urandom;
            opb[i] = ($urandom_range(0, 5) == 0) ? {1'($urandom_range(0, 1)), 31'd0} : $urandom;
         end
         run_txn("random", NUM_REQ'($urandom_range(1, 15)), $urandom_range(1, 8),
                 ($urandom_range(0, 9) != 0), $urandom, $urandom_range(0, 3),
                 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; extra_done = 1'b0;
      dv_en = 1'b0; dv_k = 1; dv_ans = '0; model_last = NUM_REQ - 1;
      for (int i = 0; i < NUM_REQ; i++) begin
         opa[i] = '0; opb[i] = '0;
      end
      test_reset();
      test_single_divide();
      test_round_robin();
      test_div_zero();
      test_timeout();
      test_backpressure();
      test_reset_in_wait();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
